mul_arb: RTL

//  Round-robin scheduler that shares one iterative shift-add unsigned multiplier between NREQ

---
 rtl/mul_arb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mul_arb.sv
// Round-robin arbiter sharing one iterative shift-add unsigned multiplier among NREQ requesters.
// Operands are captured at grant; the product is returned with a one-cycle one-hot ack.
module mul_arb #(
    parameter int N    = 8,
    parameter int M    = 3,
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] x_in,
    input  logic [NREQ*N-1:0] y_in,
    output logic [NREQ-1:0]   ack,
    output logic [2*N-1:0]    r,
    output logic [IW-1:0]     rsp_id,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q,  state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N-1:0]    xs_q,     xs_d;
    logic [N-1:0]    ys_q,     ys_d;
    logic [IW-1:0]   id_q,     id_d;
    logic [2*N-1:0]  acc_q,    acc_d;
    logic [M-1:0]    step_q,   step_d;
    logic [NREQ-1:0] ack_q,    ack_d;
    logic [2*N-1:0]  r_q,      r_d;
    logic [IW-1:0]   rsp_id_q, rsp_id_d;

    logic [IW-1:0]   win;
    logic            found;
    int unsigned     idx;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        id_d     = id_q;
        acc_d    = acc_q;
        step_d   = step_q;
        ack_d    = '0;
        r_d      = r_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    xs_d    = x_in[win*N +: N];
                    ys_d    = y_in[win*N +: N];
                    id_d    = win;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d  = {acc_q[2*N-2:0], 1'b0} + (ys_q[N-1] ? {{N{1'b0}}, xs_q} : '0);
                ys_d   = {ys_q[N-2:0], 1'b0};
                step_d = step_q + 1'b1;
                if (step_q == M'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ack_d    = NREQ'(1) << id_q;
                r_d      = acc_q;
                rsp_id_d = id_q;
                rr_ptr_d = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            xs_q     <= '0;
            ys_q     <= '0;
            id_q     <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            ack_q    <= '0;
            r_q      <= '0;
            rsp_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            id_q     <= id_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            ack_q    <= ack_d;
            r_q      <= r_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    assign ack    = ack_q;
    assign r      = r_q;
    assign rsp_id = rsp_id_q;
    assign busy   = (state_q == S_BUSY) || (state_q == S_DONE);

endmodule
